seq_sign_normalizer: RTL and testbench
======================================

Name: seq_sign_normalizer

Overview:
- Multi-cycle sign normalizer for the 32-bit shifter datapath. It is the inverse of the barrel shifter: the shifter takes an amount and produces data, while this block takes data and produces the amount.
- Shifts an operand left, in steps of 4 (coarse) or 1 (fine), until bit 31 differs from bit 30.
- Returns the normalized word and the 5-bit left-shift amount SH_AMT. Feeding the original operand and SH_AMT into the 32-bit shifter with SH_DIR=0 reproduces D_OUT.
- Valid/ready on both sides. Sits ahead of the shifter in the FP/normalize path.

Parameters:
- DATA_W, 32, operand width. Only 32 is verified.
- AMT_W, 5, shift-amount width; equals log2(DATA_W).
- COARSE, 4, coarse step size. Must be less than DATA_W.

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- IN_VALID  input  1  operand valid
- IN_READY  output  1  block can accept an operand
- D_IN  input  32  signed operand
- OUT_VALID  output  1  result valid
- OUT_READY  input  1  consumer accepts the result
- D_OUT  output  32  normalized operand (working register)
- SH_AMT  output  5  total left shift applied (working counter)
- OUT_ZERO  output  1  only when NORM_ZERO_DET_EN is defined; see Optional Feature

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE, D_OUT=0, SH_AMT=0, OUT_VALID=0, IN_READY=1, OUT_ZERO=0.
  - Reset mid-operation discards the operand in flight; no partial result is ever presented.
- States: IDLE, SHIFT, DONE. IN_READY=1 only in IDLE. OUT_VALID=1 only in DONE.
- IDLE: on a rising edge with IN_VALID=1, load D_OUT<=D_IN, set SH_AMT<=0, go to SHIFT.
- SHIFT: each edge performs exactly one of the following, in priority order:
  - Coarse step: top 5 bits of D_OUT all equal and SH_AMT+4 <= 31. Then D_OUT<={D_OUT[27:0],4'b0} and SH_AMT+=4.
  - Fine step: D_OUT[31]==D_OUT[30] and SH_AMT < 31. Then D_OUT<={D_OUT[30:0],1'b0} and SH_AMT+=1.
  - Otherwise go to DONE; D_OUT and SH_AMT hold.
- SH_AMT never exceeds 31 (saturation guard in both conditions); there is no wrap.
- All-zero or all-ones input terminates with SH_AMT=31 after 7 coarse and 3 fine steps.
- Latency: OUT_VALID rises (steps+1) edges after the accept edge. An operand that is already normalized takes 1 edge. Worst case is 11 edges.
- DONE: D_OUT and SH_AMT are stable while OUT_VALID=1.
  - On an edge with OUT_READY=1, go to IDLE; the registers hold their last values.
  - IN_READY stays 0 during DONE, so there is no same-cycle accept and release. The next operand is accepted at the earliest one edge after release.
- IN_VALID is ignored outside IDLE. D_IN only needs to be valid on the accept edge.

Optional Feature:
- Macro: NORM_ZERO_DET_EN.
- Defined:
  - OUT_ZERO port present.
  - On the accept edge, if D_IN is all zeros or all ones: load D_OUT<=D_IN<<31 and SH_AMT<=31, go directly to DONE (1-edge latency). OUT_ZERO<=1 only when D_IN==0.
  - OUT_ZERO holds through DONE and clears on the next accept.
- Undefined:
  - No OUT_ZERO port.
  - All-sign inputs take the normal 10-step path.
  - Final D_OUT and SH_AMT are identical in both builds.

Decomposition:
- Package norm_pkg:
  - state enum (IDLE/SHIFT/DONE)
  - DATA_W, AMT_W, COARSE and AMT_MAX=31 constants
- Sub-module norm_step: combinational single-step decision.
  - Inputs: D_OUT, SH_AMT.
  - Outputs: next data, next amount, a 'done' flag.
  - The top-level FSM instantiates norm_step once.

Test Plan:
- D_IN=0x40000000 -> OUT_VALID 1 edge after accept; D_OUT=0x40000000, SH_AMT=0.
- D_IN=0x00000001 -> 7 coarse + 2 fine steps, OUT_VALID after 10 edges; D_OUT=0x40000000, SH_AMT=30.
- D_IN=0xFFFF0000 -> steps 4,8,12,13,14,15; D_OUT=0x80000000, SH_AMT=15, after 7 edges.
- D_IN=0x00000000 -> SH_AMT=31, D_OUT=0, after 11 edges (macro off); after 1 edge with OUT_ZERO=1 (macro on).
- Backpressure: hold OUT_READY=0 for 5 cycles in DONE -> D_OUT/SH_AMT stable, IN_READY=0; release -> IN_READY=1 on the next cycle, and a new operand with IN_VALID held high is accepted one edge later.
- Reset: assert RST_N=0 during SHIFT on 0x00000001 -> all outputs zero immediately (asynchronous), IN_READY=1; the next operand 0x00000003 -> SH_AMT=29, D_OUT=0x60000000.

Source files
------------

// File: rtl/seq_sign_normalizer_pkg.sv
// Shared types and constants for the sequential sign normalizer.
// Holds the FSM state enum, datapath widths and an all-sign helper.
package norm_pkg;

    localparam int DATA_W  = 32;
    localparam int AMT_W   = 5;
    localparam int COARSE  = 4;
    localparam int AMT_MAX = 31;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // True for operands with no significant bits (0 or -1).
    function automatic logic all_sign(input logic [DATA_W-1:0] d);
        return (d == '0) || (&d);
    endfunction

endpackage

// File: rtl/seq_sign_normalizer_if.sv
// Operand/result handshake bundle for the sign normalizer.
// slave: the normalizer; master: the producer/consumer side.
// OUT_ZERO exists only when NORM_ZERO_DET_EN is defined.
interface seq_sign_normalizer_if;
    import norm_pkg::*;

    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] D_IN;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [DATA_W-1:0] D_OUT;
    logic [AMT_W-1:0]  SH_AMT;
`ifdef NORM_ZERO_DET_EN
    logic              OUT_ZERO;
`endif

    modport slave (
        input  IN_VALID,
        input  D_IN,
        input  OUT_READY,
        output IN_READY,
        output OUT_VALID,
        output D_OUT,
`ifdef NORM_ZERO_DET_EN
        output OUT_ZERO,
`endif
        output SH_AMT
    );

    modport master (
        output IN_VALID,
        output D_IN,
        output OUT_READY,
        input  IN_READY,
        input  OUT_VALID,
        input  D_OUT,
`ifdef NORM_ZERO_DET_EN
        input  OUT_ZERO,
`endif
        input  SH_AMT
    );

endinterface

// File: rtl/seq_sign_normalizer_step.sv
// Combinational single-step decision for the normalizer.
// In: d_i, amt_i. Out: d_o, amt_o (next values), done_o (no step left).
module norm_step
    import norm_pkg::*;
(
    input  logic [DATA_W-1:0] d_i,
    input  logic [AMT_W-1:0]  amt_i,
    output logic [DATA_W-1:0] d_o,
    output logic [AMT_W-1:0]  amt_o,
    output logic              done_o
);

    logic [COARSE:0] top;
    logic [AMT_W:0]  amt_x;
    logic            coarse_ok;
    logic            fine_ok;

    assign top   = d_i[DATA_W-1 -: COARSE+1];
    // One extra bit so the +COARSE guard cannot wrap.
    assign amt_x = {1'b0, amt_i};

    // Top COARSE+1 bits equal: COARSE of them are redundant sign bits.
    assign coarse_ok = ((top == '0) || (&top))
                    && ((amt_x + (AMT_W+1)'(COARSE))
                        <= (AMT_W+1)'(AMT_MAX));

    assign fine_ok = (d_i[DATA_W-1] == d_i[DATA_W-2])
                  && (amt_i < AMT_W'(AMT_MAX));

    always_comb begin
        d_o    = d_i;
        amt_o  = amt_i;
        done_o = 1'b0;
        priority case (1'b1)
            coarse_ok: begin
                d_o   = d_i << COARSE;
                amt_o = amt_i + AMT_W'(COARSE);
            end
            fine_ok: begin
                d_o   = d_i << 1;
                amt_o = amt_i + AMT_W'(1);
            end
            default: done_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seq_sign_normalizer.sv
// Multi-cycle sign normalizer: shifts left until bit31 != bit30.
// Ports: CLK, RST_N (async low), bus (slave: IN_*/D_IN in,
// OUT_*/D_OUT/SH_AMT out). Option macro: NORM_ZERO_DET_EN
// (adds OUT_ZERO and a one-edge shortcut for all-sign operands).
module seq_sign_normalizer
    import norm_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST_N,
    seq_sign_normalizer_if.slave bus
);

    state_e            state_q;
    logic [DATA_W-1:0] d_q;
    logic [AMT_W-1:0]  amt_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [DATA_W-1:0] d_d;
    logic [AMT_W-1:0]  amt_d;
    logic              done_d;

    norm_step u_step (
        .d_i    (d_q),
        .amt_i  (amt_q),
        .d_o    (d_d),
        .amt_o  (amt_d),
        .done_o (done_d)
    );

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.D_OUT     = d_q;
    assign bus.SH_AMT    = amt_q;

`ifdef NORM_ZERO_DET_EN
    logic zero_q;

    assign bus.OUT_ZERO = zero_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            zero_q <= 1'b0;
        end else if (state_q == IDLE && bus.IN_VALID) begin
            zero_q <= (bus.D_IN == '0);
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            d_q         <= '0;
            amt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.IN_VALID) begin
                        d_q        <= bus.D_IN;
                        amt_q      <= '0;
                        state_q    <= SHIFT;
                        in_ready_q <= 1'b0;
`ifdef NORM_ZERO_DET_EN
                        // Same end result as the full walk, in one edge.
                        if (all_sign(bus.D_IN)) begin
                            d_q         <= bus.D_IN << (DATA_W-1);
                            amt_q       <= AMT_W'(AMT_MAX);
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
`endif
                    end
                end
                SHIFT: begin
                    if (done_d) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        d_q   <= d_d;
                        amt_q <= amt_d;
                    end
                end
                DONE: begin
                    // Registers hold; ready returns only in IDLE.
                    if (bus.OUT_READY) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sign_normalizer.sv
// Directed self-checking bench for seq_sign_normalizer.
// Covers reset, latencies, all-sign operands, backpressure, async reset.
module tb_seq_sign_normalizer;

    logic CLK = 1'b0;
    logic RST_N;
    int   checks   = 0;
    int   failures = 0;

`ifdef NORM_ZERO_DET_EN
    localparam int SIGN_LAT = 1;
`else
    localparam int SIGN_LAT = 11;
`endif

    always #5 CLK = ~CLK;

    seq_sign_normalizer_if bus ();

    seq_sign_normalizer dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    task automatic send(input logic [31:0] d);
        @(negedge CLK);
        bus.IN_VALID = 1'b1;
        bus.D_IN     = d;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        bus.D_IN     = '0;
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK);
            #1;
            if (bus.OUT_VALID) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_release;
        @(negedge CLK);
        bus.OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        bus.OUT_READY = 1'b0;
    endtask

    task automatic test_reset;
        RST_N         = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        bus.D_IN      = '0;
        repeat (2) @(negedge CLK);
        checks++;
        if (bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL rst_hs actual=%b/%b required=1/0",
                     bus.IN_READY, bus.OUT_VALID);
        end
        checks++;
        if (bus.D_OUT !== 32'h0 || bus.SH_AMT !== 5'd0) begin
            failures++;
            $display("FAIL rst_data actual=%h/%0d required=0/0",
                     bus.D_OUT, bus.SH_AMT);
        end
`ifdef NORM_ZERO_DET_EN
        checks++;
        if (bus.OUT_ZERO !== 1'b0) begin
            failures++;
            $display("FAIL rst_zero actual=%b required=0", bus.OUT_ZERO);
        end
`endif
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_normalized;
        int n;
        send(32'h4000_0000);
        wait_valid(n);
        checks++;
        if (n !== 1) begin
            failures++;
            $display("FAIL norm_lat actual=%0d required=1", n);
        end
        checks++;
        if (bus.D_OUT !== 32'h4000_0000 || bus.SH_AMT !== 5'd0) begin
            failures++;
            $display("FAIL norm_res actual=%h/%0d required=40000000/0",
                     bus.D_OUT, bus.SH_AMT);
        end
        do_release();
    endtask

    task automatic test_one;
        int n;
        send(32'h0000_0001);
        wait_valid(n);
        checks++;
        if (n !== 10) begin
            failures++;
            $display("FAIL one_lat actual=%0d required=10", n);
        end
        checks++;
        if (bus.D_OUT !== 32'h4000_0000 || bus.SH_AMT !== 5'd30) begin
            failures++;
            $display("FAIL one_res actual=%h/%0d required=40000000/30",
                     bus.D_OUT, bus.SH_AMT);
        end
        do_release();
    endtask

    task automatic test_negative;
        int n;
        send(32'hFFFF_0000);
        wait_valid(n);
        checks++;
        if (n !== 7) begin
            failures++;
            $display("FAIL neg_lat actual=%0d required=7", n);
        end
        checks++;
        if (bus.D_OUT !== 32'h8000_0000 || bus.SH_AMT !== 5'd15) begin
            failures++;
            $display("FAIL neg_res actual=%h/%0d required=80000000/15",
                     bus.D_OUT, bus.SH_AMT);
        end
        do_release();
    endtask

    task automatic test_all_sign;
        int n;
        send(32'h0000_0000);
        wait_valid(n);
        checks++;
        if (n !== SIGN_LAT) begin
            failures++;
            $display("FAIL zero_lat actual=%0d required=%0d", n, SIGN_LAT);
        end
        checks++;
        if (bus.D_OUT !== 32'h0 || bus.SH_AMT !== 5'd31) begin
            failures++;
            $display("FAIL zero_res actual=%h/%0d required=0/31",
                     bus.D_OUT, bus.SH_AMT);
        end
`ifdef NORM_ZERO_DET_EN
        checks++;
        if (bus.OUT_ZERO !== 1'b1) begin
            failures++;
            $display("FAIL zero_flag actual=%b required=1", bus.OUT_ZERO);
        end
`endif
        do_release();
        send(32'hFFFF_FFFF);
        wait_valid(n);
        checks++;
        if (n !== SIGN_LAT) begin
            failures++;
            $display("FAIL ones_lat actual=%0d required=%0d", n, SIGN_LAT);
        end
        checks++;
        if (bus.D_OUT !== 32'h8000_0000 || bus.SH_AMT !== 5'd31) begin
            failures++;
            $display("FAIL ones_res actual=%h/%0d required=80000000/31",
                     bus.D_OUT, bus.SH_AMT);
        end
`ifdef NORM_ZERO_DET_EN
        checks++;
        if (bus.OUT_ZERO !== 1'b0) begin
            failures++;
            $display("FAIL ones_flag actual=%b required=0", bus.OUT_ZERO);
        end
`endif
        do_release();
    endtask

    task automatic test_backpressure;
        int n;
        send(32'h4000_0000);
        wait_valid(n);
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (bus.OUT_VALID !== 1'b1 || bus.IN_READY !== 1'b0 ||
                bus.D_OUT !== 32'h4000_0000 || bus.SH_AMT !== 5'd0) begin
                failures++;
                $display("FAIL bp_hold%0d actual=%b/%b/%h/%0d required=1/0/40000000/0",
                         c, bus.OUT_VALID, bus.IN_READY, bus.D_OUT, bus.SH_AMT);
            end
        end
        @(negedge CLK);
        bus.OUT_READY = 1'b1;
        bus.IN_VALID  = 1'b1;
        bus.D_IN      = 32'h2000_0000;
        @(posedge CLK);
        #1;
        bus.OUT_READY = 1'b0;
        checks++;
        if (bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0 ||
            bus.D_OUT !== 32'h4000_0000) begin
            failures++;
            $display("FAIL bp_release actual=%b/%b/%h required=1/0/40000000",
                     bus.IN_READY, bus.OUT_VALID, bus.D_OUT);
        end
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.IN_READY !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept actual=%b required=0", bus.IN_READY);
        end
        wait_valid(n);
        checks++;
        if (n !== 2 || bus.D_OUT !== 32'h4000_0000 || bus.SH_AMT !== 5'd1) begin
            failures++;
            $display("FAIL bp_next actual=%0d/%h/%0d required=2/40000000/1",
                     n, bus.D_OUT, bus.SH_AMT);
        end
        do_release();
    endtask

    task automatic test_async_reset;
        int n;
        send(32'h0000_0001);
        repeat (3) @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        checks++;
        if (bus.D_OUT !== 32'h0 || bus.SH_AMT !== 5'd0 ||
            bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
            failures++;
            $display("FAIL arst actual=%h/%0d/%b/%b required=0/0/0/1",
                     bus.D_OUT, bus.SH_AMT, bus.OUT_VALID, bus.IN_READY);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        send(32'h0000_0003);
        wait_valid(n);
        checks++;
        if (n !== 9 || bus.D_OUT !== 32'h6000_0000 || bus.SH_AMT !== 5'd29) begin
            failures++;
            $display("FAIL arst_next actual=%0d/%h/%0d required=9/60000000/29",
                     n, bus.D_OUT, bus.SH_AMT);
        end
        do_release();
    endtask

    initial begin
        test_reset();
        test_normalized();
        test_one();
        test_negative();
        test_all_sign();
        test_backpressure();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
